// File: rtl/iob_tb_ext_mem.sv
// Memory responder for the SoC external-memory and boot-ROM ports.
// Byte-strobe writes, a fixed read latency, FILL_WORD for unwritten words, and access diagnostics.
module iob_tb_ext_mem #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 12,
    parameter int                RD_LAT    = 1,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(32'h0000_0013),
    parameter int                CNT_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    input  logic                  r_en_i,
    input  logic [ADDR_W-1:0]     r_addr_i,
    output logic [DATA_W-1:0]     r_data_o,
    output logic                  r_valid_o,
    input  logic [DATA_W/8-1:0]   w_strb_i,
    input  logic [ADDR_W-1:0]     w_addr_i,
    input  logic [DATA_W-1:0]     w_data_i,
    output logic                  uninit_rd_o,
    output logic [CNT_W-1:0]      rd_cnt_o,
    output logic [CNT_W-1:0]      wr_cnt_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_lat
        $error("iob_tb_ext_mem: RD_LAT must be in 1..8");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("iob_tb_ext_mem: DATA_W must be a multiple of 8");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;

    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_base;
    logic [DATA_W-1:0] wr_word;

    logic [RD_LAT-1:0] pv;
    logic [DATA_W-1:0] pd [RD_LAT];

    assign rd = cke_i && r_en_i;
    assign wr = cke_i && (w_strb_i != '0);

    // Reads see the pre-edge contents, so a same-address write in the same cycle is not visible.
    assign rd_word = written[r_addr_i] ? mem[r_addr_i] : FILL_WORD;

    always_comb begin
        wr_base = written[w_addr_i] ? mem[w_addr_i] : FILL_WORD;
        wr_word = wr_base;
        for (int i = 0; i < NB; i++) begin
            if (w_strb_i[i]) begin
                wr_word[8*i +: 8] = w_data_i[8*i +: 8];
            end
        end
    end

    // Storage is deliberately not reset; the written bitmap masks stale contents.
    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem[w_addr_i] <= wr_word;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            written <= '0;
        end else if (wr) begin
            written[w_addr_i] <= 1'b1;
        end
    end

    // Data in each stage only moves with a valid, so the last stage holds the last valid word.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pv <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pd[i] <= '0;
            end
        end else if (cke_i) begin
            pv[0] <= rd;
            if (rd) begin
                pd[0] <= rd_word;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pd[i] <= pd[i-1];
                end
            end
        end
    end

    assign r_valid_o = pv[RD_LAT-1];
    assign r_data_o  = pd[RD_LAT-1];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            uninit_rd_o <= 1'b0;
            rd_cnt_o    <= '0;
            wr_cnt_o    <= '0;
        end else begin
            if (rd && !written[r_addr_i]) begin
                uninit_rd_o <= 1'b1;
            end
            if (rd && (rd_cnt_o != '1)) begin
                rd_cnt_o <= rd_cnt_o + 1'b1;
            end
            if (wr && (wr_cnt_o != '1)) begin
                wr_cnt_o <= wr_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iob_tb_ext_mem.sv
// Directed bench for iob_tb_ext_mem: three instances share one stimulus stream
// and differ in read latency (1, 4, 3) and counter width (16, 4, 16).
module tb_iob_tb_ext_mem;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        cke;
    logic        r_en;
    logic [11:0] r_addr;
    logic [3:0]  w_strb;
    logic [11:0] w_addr;
    logic [31:0] w_data;

    logic [31:0] d1_rdata, d4_rdata, d3_rdata;
    logic        d1_rvalid, d4_rvalid, d3_rvalid;
    logic        d1_uninit, d4_uninit, d3_uninit;
    logic [15:0] d1_rdcnt, d1_wrcnt, d3_rdcnt, d3_wrcnt;
    logic [3:0]  d4_rdcnt, d4_wrcnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    iob_tb_ext_mem #(.RD_LAT(1), .CNT_W(16)) d1 (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .r_en_i(r_en), .r_addr_i(r_addr),
        .r_data_o(d1_rdata), .r_valid_o(d1_rvalid), .w_strb_i(w_strb), .w_addr_i(w_addr),
        .w_data_i(w_data), .uninit_rd_o(d1_uninit), .rd_cnt_o(d1_rdcnt), .wr_cnt_o(d1_wrcnt)
    );

    iob_tb_ext_mem #(.RD_LAT(4), .CNT_W(4)) d4 (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .r_en_i(r_en), .r_addr_i(r_addr),
        .r_data_o(d4_rdata), .r_valid_o(d4_rvalid), .w_strb_i(w_strb), .w_addr_i(w_addr),
        .w_data_i(w_data), .uninit_rd_o(d4_uninit), .rd_cnt_o(d4_rdcnt), .wr_cnt_o(d4_wrcnt)
    );

    iob_tb_ext_mem #(.RD_LAT(3), .CNT_W(16)) d3 (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .r_en_i(r_en), .r_addr_i(r_addr),
        .r_data_o(d3_rdata), .r_valid_o(d3_rvalid), .w_strb_i(w_strb), .w_addr_i(w_addr),
        .w_data_i(w_data), .uninit_rd_o(d3_uninit), .rd_cnt_o(d3_rdcnt), .wr_cnt_o(d3_wrcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cke    = 1'b1;
        r_en   = 1'b0;
        w_strb = 4'h0;
    endtask

    task automatic do_reset();
        idle();
        arst_n = 1'b0;
        tick();
        tick();
        arst_n = 1'b1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        w_addr = a;
        w_data = d;
        w_strb = s;
        tick();
        w_strb = 4'h0;
    endtask

    task automatic rd1(input logic [11:0] a);
        r_addr = a;
        r_en   = 1'b1;
        tick();
        r_en   = 1'b0;
    endtask

    initial begin
        arst_n = 1'b0;
        r_addr = '0;
        w_addr = '0;
        w_data = '0;
        idle();
        tick();
        tick();
        check("rst_rvalid", {31'b0, d1_rvalid}, 32'h0);
        check("rst_rdata",  d1_rdata, 32'h0);
        check("rst_uninit", {31'b0, d1_uninit}, 32'h0);
        check("rst_rdcnt",  {16'b0, d1_rdcnt}, 32'h0);
        check("rst_wrcnt",  {16'b0, d1_wrcnt}, 32'h0);
        arst_n = 1'b1;

        // Fresh read returns the fill word and flags it
        rd1(12'h010);
        check("fill_valid",  {31'b0, d1_rvalid}, 32'h1);
        check("fill_data",   d1_rdata, 32'h0000_0013);
        check("fill_uninit", {31'b0, d1_uninit}, 32'h1);
        check("fill_rdcnt",  {16'b0, d1_rdcnt}, 32'h1);
        tick();
        check("valid_drop",  {31'b0, d1_rvalid}, 32'h0);
        check("data_hold",   d1_rdata, 32'h0000_0013);

        do_reset();
        check("uninit_clr", {31'b0, d1_uninit}, 32'h0);
        wr(12'h020, 32'hDEAD_BEEF, 4'hF);
        check("full_wrcnt", {16'b0, d1_wrcnt}, 32'h1);
        rd1(12'h020);
        check("full_data",   d1_rdata, 32'hDEAD_BEEF);
        check("full_uninit", {31'b0, d1_uninit}, 32'h0);

        wr(12'h030, 32'hAABB_CCDD, 4'b0101);
        rd1(12'h030);
        check("merge_fill", d1_rdata, 32'h00BB_00DD);
        wr(12'h030, 32'h1122_3344, 4'b1000);
        rd1(12'h030);
        check("merge_data", d1_rdata, 32'h11BB_00DD);

        // Same-address read and write in one cycle: read sees the old word
        wr(12'h040, 32'h1111_1111, 4'hF);
        r_addr = 12'h040;
        r_en   = 1'b1;
        w_addr = 12'h040;
        w_data = 32'h2222_2222;
        w_strb = 4'hF;
        tick();
        idle();
        check("rbw_old", d1_rdata, 32'h1111_1111);
        rd1(12'h040);
        check("rbw_new", d1_rdata, 32'h2222_2222);
        check("rw_wrcnt", {16'b0, d1_wrcnt}, 32'd5);

        // Four-cycle latency with a two-cycle clock-enable stall mid-stream
        do_reset();
        wr(12'h001, 32'h0000_000A, 4'hF);
        wr(12'h002, 32'h0000_000B, 4'hF);
        wr(12'h003, 32'h0000_000C, 4'hF);
        check("l4_wrcnt", {28'b0, d4_wrcnt}, 32'd3);
        r_en = 1'b1;
        r_addr = 12'h001; tick();
        r_addr = 12'h002; tick();
        r_addr = 12'h003; tick();
        r_en = 1'b0;
        check("l4_early", {31'b0, d4_rvalid}, 32'h0);
        tick();
        check("l4_v0", {31'b0, d4_rvalid}, 32'h1);
        check("l4_d0", d4_rdata, 32'h0000_000A);
        cke = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("l4_stall_v", {31'b0, d4_rvalid}, 32'h1);
            check("l4_stall_d", d4_rdata, 32'h0000_000A);
        end
        cke = 1'b1;
        tick();
        check("l4_v1", {31'b0, d4_rvalid}, 32'h1);
        check("l4_d1", d4_rdata, 32'h0000_000B);
        tick();
        check("l4_v2", {31'b0, d4_rvalid}, 32'h1);
        check("l4_d2", d4_rdata, 32'h0000_000C);
        tick();
        check("l4_end_v", {31'b0, d4_rvalid}, 32'h0);
        check("l4_end_d", d4_rdata, 32'h0000_000C);

        // Counter saturation on the 4-bit instance
        do_reset();
        r_addr = 12'h000;
        r_en   = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("sat_15", {28'b0, d4_rdcnt}, 32'hF);
        for (int i = 0; i < 5; i++) tick();
        r_en = 1'b0;
        check("sat_20",    {28'b0, d4_rdcnt}, 32'hF);
        check("nosat_20",  {16'b0, d1_rdcnt}, 32'd20);
        check("sat_uninit", {31'b0, d4_uninit}, 32'h1);

        // Reset with two reads in flight on the three-cycle instance
        wr(12'h050, 32'h1234_5678, 4'hF);
        r_addr = 12'h050;
        r_en   = 1'b1;
        tick();
        tick();
        r_en   = 1'b0;
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_valid", {31'b0, d3_rvalid}, 32'h0);
        end
        check("flush_rdcnt", {16'b0, d3_rdcnt}, 32'h0);
        check("flush_wrcnt", {16'b0, d3_wrcnt}, 32'h0);
        rd1(12'h050);
        tick();
        tick();
        check("l3_valid",  {31'b0, d3_rvalid}, 32'h1);
        check("l3_fill",   d3_rdata, 32'h0000_0013);
        check("l3_uninit", {31'b0, d3_uninit}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_tb_ext_mem.md
Name: iob_tb_ext_mem

Overview:
Parametrised simulation/FPGA-test memory responder for the SoC's external-memory and boot-ROM ports. It replaces constant tie-offs with:
- a real word-addressed store with byte-strobe writes;
- configurable read latency;
- a fill word returned for never-written locations (default RISC-V NOP);
- sticky diagnostics and access counters.

It sits in the bench top, driven directly by the SoC's ext_mem_* or bootrom_mem_* outputs.

Parameters:
DATA_W, 32, data width in bits; multiple of 8.
ADDR_W, 12, word-address width; DEPTH = 2**ADDR_W words.
RD_LAT, 1, read latency in enabled cycles; legal range 1..8.
FILL_WORD, 32'h0000_0013, value returned for unwritten words.
CNT_W, 16, width of the access counters.

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
cke_i  in  1  clock enable; 0 freezes all state
r_en_i  in  1  read request this cycle
r_addr_i  in  ADDR_W  read word address
r_data_o  out  DATA_W  read data
r_valid_o  out  1  r_data_o valid strobe, one cycle per request
w_strb_i  in  DATA_W/8  byte write enables; nonzero = write
w_addr_i  in  ADDR_W  write word address
w_data_i  in  DATA_W  write data
uninit_rd_o  out  1  sticky: a read hit an unwritten word
rd_cnt_o  out  CNT_W  accepted reads, saturating
wr_cnt_o  out  CNT_W  accepted writes, saturating

Behaviour:
- Reset (arst_n_i=0, async), all outputs and state take these values:
  - r_data_o=0, r_valid_o=0, uninit_rd_o=0, rd_cnt_o=0, wr_cnt_o=0.
  - Read pipeline emptied.
  - Per-word written bitmap cleared. Storage array contents are not reset; the cleared bitmap makes every word read back as FILL_WORD.
- cke_i=0: no write, no read accept, pipeline holds. r_valid_o and r_data_o keep their values, so a pending valid stays asserted until cke returns.
- Write (cke_i=1, w_strb_i!=0):
  - Each byte i with w_strb_i[i]=1 is stored.
  - The word's written bit is set.
  - Byte merge on a previously unwritten word: unstrobed bytes take the matching FILL_WORD bytes, so a partial write to a fresh word reads back as fill/data mix.
  - wr_cnt_o increments, saturating at all-ones.
- Read accept (cke_i=1, r_en_i=1):
  - Word value is sampled at the accept edge: stored word if written, else FILL_WORD.
  - If the word is unwritten, uninit_rd_o is set (sticky until reset).
  - rd_cnt_o increments, saturating.
- Latency:
  - A read accepted at enabled edge N presents r_valid_o=1 with its data after enabled edge N+RD_LAT-1.
  - RD_LAT=1: data visible the cycle after the request. RD_LAT=k: k-stage shift of {valid,data}.
  - Back-to-back reads are fully pipelined: one per cycle, in order, no bubbles.
- r_data_o holds the last valid data when r_valid_o=0.
- Same-address read and write in one cycle: read-before-write; the read returns the pre-write value or FILL_WORD, and the write still lands.
- Simultaneous read and write to different addresses: both proceed independently.
- Counters and sticky flag update on the same edge as the access.
- Reset asserted mid-pipeline: in-flight reads are dropped, with no valid after release.
- Address width is exact (DEPTH=2**ADDR_W); no out-of-range case.
- Elaboration error if RD_LAT<1, RD_LAT>8, or DATA_W%8!=0.

Test Plan:
- Reset then read addr 0x010 with RD_LAT=1 -> r_valid_o=1 next cycle, r_data_o=0x0000_0013, uninit_rd_o=1, rd_cnt_o=1.
- Write 0xDEAD_BEEF strb 4'hF to 0x020, then read 0x020 -> 0xDEAD_BEEF; wr_cnt_o=1; uninit_rd_o stays 0 after a fresh reset.
- Fresh word 0x030, write 0xAABB_CCDD strb 4'b0101 -> reads back 0x00BB_00DD. Then write 0x1122_3344 strb 4'b1000 -> reads back 0x11BB_00DD.
- RD_LAT=4, reads of 0x1,0x2,0x3 on consecutive cycles (pre-written 0xA,0xB,0xC) -> r_valid_o high for 3 consecutive cycles starting 4 cycles after the first request, data 0xA,0xB,0xC. Deassert cke_i for 2 cycles mid-stream -> outputs hold, then resume in order with no loss.
- Same cycle read and write 0x040 (old 0x1111_1111, new 0x2222_2222) -> read returns 0x1111_1111; next read returns 0x2222_2222.
- CNT_W=4 with 20 reads -> rd_cnt_o saturates at 4'hF. Assert arst_n_i with 2 reads in flight (RD_LAT=3) -> no r_valid_o after release, counters 0, a previously written address reads 0x0000_0013.
